sram_array_ctrl: RTL and testbench

//  Digital sequencer for a ROWS x COLS mixed-signal SRAM array. Drives precharge, one-hot

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_array_ctrl_if.sv | 26 ++
 rtl/sram_wl_decoder.sv | 20 ++
 rtl/sram_array_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sram_array_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and analog level constants for the SRAM array sequencer and its level checkers.
package sram_pkg;

  typedef enum logic [2:0] {IDLE, PRECH, WL, SENSE, DONE} ctrl_state_e;
  typedef enum logic [1:0] {DATA_TRUE, DATA_FALSE, INDET} state_data_e;

  // Bitline level windows in millivolts; anything between the windows is indeterminate.
  localparam int TRUE_MIN  = 700;
  localparam int TRUE_MAX  = 1200;
  localparam int FALSE_MIN = 0;
  localparam int FALSE_MAX = 300;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic state_data_e classify_mv(input int mv);
    if (mv >= TRUE_MIN && mv <= TRUE_MAX)
      return DATA_TRUE;
    else if (mv >= FALSE_MIN && mv <= FALSE_MAX)
      return DATA_FALSE;
    else
      return INDET;
  endfunction

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Request/response handshake bundle between a requester and the SRAM array sequencer.
interface sram_array_ctrl_if #(
  parameter int ROWS = 16,
  parameter int COLS = 8
);
  localparam int AW = $clog2(ROWS) + 1;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_wl_decoder.sv
// Address-to-one-hot wordline decoder; all lines low when disabled.
module sram_wl_decoder #(
  parameter int ROWS = 16,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [ROWS-1:0] row
);

  always_comb begin
    row = '0;
    if (en) begin
      for (int i = 0; i < ROWS; i++) begin
        if (addr == AW'(i)) row[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_array_ctrl.sv
// Precharge/wordline/sense sequencer for a ROWS x COLS SRAM array.
// Define SRAM_PARITY_EN to add an even-parity column with a read-side parity check.
module sram_array_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int COLS       = 8,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2,
  localparam int AW = $clog2(ROWS) + 1,
`ifdef SRAM_PARITY_EN
  localparam int CW = COLS + 1
`else
  localparam int CW = COLS
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_array_ctrl_if.slave  bus,
  output logic              precharge,
  output logic [ROWS-1:0]   row_wr,
  output logic [ROWS-1:0]   row_rd,
  output logic [CW-1:0]     data_in,
  output logic              sa_en,
  input  logic [CW-1:0]     sa_out,
  input  logic [CW-1:0]     sa_indet
);

  // state  | meaning
  // IDLE   | ready for a request
  // PRECH  | bitline precharge, PRE_CYCLES long
  // WL     | selected wordline on, WL_CYCLES long
  // SENSE  | reads only: wordline held, sense amps enabled, result sampled at exit
  // DONE   | one-cycle response pulse

  localparam int               MAXC     = max_int(PRE_CYCLES, WL_CYCLES);
  localparam int               CNT_W    = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);
  localparam logic [AW-1:0]    ROWS_A   = AW'(ROWS);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [COLS-1:0]  wdata_q, wdata_d;
  logic [COLS-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [CW-1:0]    wdata_cw;
  logic [COLS-1:0]  sense_data;
  logic             sense_err;
  logic             wr_en;
  logic             rd_en;

`ifdef SRAM_PARITY_EN
  assign wdata_cw   = {^wdata_q, wdata_q};
  assign sense_data = sa_out[COLS-1:0];
  assign sense_err  = (|sa_indet) | (^sa_out);
`else
  assign wdata_cw   = wdata_q;
  assign sense_data = sa_out;
  assign sense_err  = |sa_indet;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          if (bus.req_addr >= ROWS_A) begin
            // Bad address never touches the array.
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = PRECH;
            cnt_d   = PRE_LOAD;
          end
        end
      end
      PRECH: begin
        if (cnt_q == '0) begin
          state_d = WL;
          cnt_d   = WL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WL: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            state_d = SENSE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SENSE: begin
        state_d = DONE;
        rdata_d = sense_data;
        err_d   = sense_err;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign precharge = (state_q == PRECH);
  assign sa_en     = (state_q == SENSE);
  assign wr_en     = (state_q == WL) && we_q;
  assign rd_en     = ((state_q == WL) || (state_q == SENSE)) && !we_q;
  assign data_in   = (((state_q == PRECH) || (state_q == WL)) && we_q) ? wdata_cw : '0;

  sram_wl_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_wr (
    .addr (addr_q),
    .en   (wr_en),
    .row  (row_wr)
  );

  sram_wl_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_rd (
    .addr (addr_q),
    .en   (rd_en),
    .row  (row_rd)
  );

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed table-driven bench for sram_array_ctrl at default parameters (parity column when SRAM_PARITY_EN).
module tb_sram_array_ctrl;

`ifdef SRAM_PARITY_EN
  localparam int CW = 9;
`else
  localparam int CW = 8;
`endif

  typedef struct {
    logic          we;
    logic [4:0]    addr;
    logic [7:0]    wdata;
    logic [CW-1:0] sa;
    logic [7:0]    indet;
    logic [15:0]   row;
    int            lat;
    logic [7:0]    rdata;
    logic          err;
    int            n_pre;
    int            n_wl;
    int            n_sa;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           precharge;
  logic [15:0]    row_wr;
  logic [15:0]    row_rd;
  logic [CW-1:0]  data_in;
  logic           sa_en;
  logic [CW-1:0]  sa_out = '0;
  logic [CW-1:0]  sa_indet = '0;

  int n_total = 0;
  int n_pass  = 0;

  sram_array_ctrl_if #(.ROWS(16), .COLS(8)) bus ();

  sram_array_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .precharge (precharge),
    .row_wr    (row_wr),
    .row_rd    (row_rd),
    .data_in   (data_in),
    .sa_en     (sa_en),
    .sa_out    (sa_out),
    .sa_indet  (sa_indet)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [CW-1:0] mk_sa(input logic [7:0] v);
`ifdef SRAM_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  function automatic vec_t mkv(input logic we, input logic [4:0] a, input logic [7:0] wd,
                               input logic [CW-1:0] sa, input logic [7:0] ind, input logic [15:0] row,
                               input int lat, input logic [7:0] rd, input logic err,
                               input int np, input int nw, input int ns);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.sa = sa; v.indet = ind; v.row = row;
    v.lat = lat; v.rdata = rd; v.err = err; v.n_pre = np; v.n_wl = nw; v.n_sa = ns;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int   lat = 1;
    int   n_pre = 0, n_wl = 0, n_sa = 0, n_bad = 0;
    logic got = 1'b0;
    logic [CW-1:0] exp_din;
    exp_din = mk_sa(v.wdata);
    @(negedge clk);
    chk({tag, "_ready_idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    sa_out        = v.sa;
    sa_indet      = CW'(v.indet);
    @(negedge clk);
    // Scramble request fields after accept: the controller must use its latched copy.
    bus.req_valid = 1'b0;
    bus.req_we    = ~v.we;
    bus.req_addr  = 5'd9;
    bus.req_wdata = 8'h3C;
    while (!got && lat <= 20) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
      end else begin
        if (precharge) n_pre++;
        if (row_wr != '0 || row_rd != '0) begin
          if (v.we ? (row_wr == v.row && row_rd == '0) : (row_rd == v.row && row_wr == '0)) n_wl++;
          else n_bad++;
          if (precharge) n_bad++;
        end
        if (sa_en) n_sa++;
        if (bus.req_ready) n_bad++;
        if (data_in != ((v.we && (precharge || row_wr != '0)) ? exp_din : '0)) n_bad++;
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_rsp_seen"}, got, 1);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rdata"}, bus.rsp_rdata, v.rdata);
    chk({tag, "_err"}, bus.rsp_err, v.err);
    chk({tag, "_ready_done"}, bus.req_ready, 0);
    chk({tag, "_precharge_cycles"}, n_pre, v.n_pre);
    chk({tag, "_wordline_cycles"}, n_wl, v.n_wl);
    chk({tag, "_sa_en_cycles"}, n_sa, v.n_sa);
    chk({tag, "_violations"}, n_bad, 0);
    @(negedge clk);
    chk({tag, "_ready_after"}, bus.req_ready, 1);
    chk({tag, "_rsp_pulse_end"}, bus.rsp_valid, 0);
    chk({tag, "_rdata_hold"}, bus.rsp_rdata, v.rdata);
    chk({tag, "_err_hold"}, bus.rsp_err, v.err);
  endtask

  initial begin
    vec_t vecs[$];
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    //                we    addr   wdata  sa            indet  row       lat rdata  err np nw ns
    vecs.push_back(mkv(1'b1, 5'd3,  8'hA5, mk_sa(8'h00), 8'h00, 16'h0008, 4, 8'h00, 0, 1, 2, 0));
    vecs.push_back(mkv(1'b0, 5'd3,  8'h00, mk_sa(8'hA5), 8'h00, 16'h0008, 5, 8'hA5, 0, 1, 3, 1));
    vecs.push_back(mkv(1'b1, 5'd16, 8'h77, mk_sa(8'h00), 8'h00, 16'h0000, 1, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mkv(1'b0, 5'd7,  8'h00, mk_sa(8'h3C), 8'h04, 16'h0080, 5, 8'h3C, 1, 1, 3, 1));
    vecs.push_back(mkv(1'b1, 5'd0,  8'hFF, mk_sa(8'h00), 8'h00, 16'h0001, 4, 8'h00, 0, 1, 2, 0));
    vecs.push_back(mkv(1'b0, 5'd15, 8'h00, mk_sa(8'h5A), 8'h00, 16'h8000, 5, 8'h5A, 0, 1, 3, 1));
    vecs.push_back(mkv(1'b0, 5'd31, 8'h00, mk_sa(8'hFF), 8'h00, 16'h0000, 1, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mkv(1'b1, 5'd15, 8'h00, mk_sa(8'h00), 8'h00, 16'h8000, 4, 8'h00, 0, 1, 2, 0));
`ifdef SRAM_PARITY_EN
    vecs.push_back(mkv(1'b1, 5'd2,  8'h07, 9'h000,       8'h00, 16'h0004, 4, 8'h00, 0, 1, 2, 0));
    vecs.push_back(mkv(1'b0, 5'd2,  8'h00, 9'h106,       8'h00, 16'h0004, 5, 8'h06, 1, 1, 3, 1));
`endif

    #12;
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    chk("reset_precharge", precharge, 0);
    chk("reset_row_wr", row_wr, 0);
    chk("reset_row_rd", row_rd, 0);
    chk("reset_data_in", data_in, 0);
    chk("reset_sa_en", sa_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef SRAM_PARITY_EN
    // Parity bit on the write drivers while the wordline is up.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd4; bus.req_wdata = 8'h07;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("parity_data_in", data_in, 9'h107);
    repeat (4) @(negedge clk);
`endif

    // Reset in the middle of the wordline phase.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd5; bus.req_wdata = 8'h11;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_prech", precharge, 1);
    @(negedge clk);
    chk("abort_wl_on", row_wr, 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_row_wr_drop", row_wr, 0);
    chk("abort_data_in", data_in, 0);
    chk("abort_precharge", precharge, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp_err", bus.rsp_err, 0);
    chk("abort_row_wr_after", row_wr, 0);

    run_vec(vecs[1], "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
